// File: rtl/vector_control_fsm.sv
// vector_control_fsm
// Multi-cycle control sequencer for a small vector-capable datapath. Each
// instruction is fetched once, decoded once, then runs the EXEC..NEXT loop
// once per lane. Scalar instructions, and LANES=1, take exactly one pass.
// All outputs are decoded from the current state and the latched fields.
// stall holds the machine in place and masks every side-effecting strobe.
module vector_control_fsm #(
  parameter  int LANES   = 4,
  parameter  int FUNCT_W = 3,
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         Opcode,
  input  logic [FUNCT_W-1:0] Funct,
  input  logic               Vec,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic               mem_ack,
  input  logic               branch_taken,
  input  logic               stall,
  output logic               PCSrc,
  output logic               pc_write,
  output logic               RegWrite,
  output logic               ImmSrc,
  output logic               ALUSrc,
  output logic               MemWrite,
  output logic               MemRead,
  output logic               MemtoReg,
  output logic [FUNCT_W-1:0] AluOp,
  output logic [LANE_W-1:0]  lane_idx,
  output logic               busy,
  output logic               halted,
  output logic               illegal
);

  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_ALUI  = 3'b001;
  localparam logic [2:0] OP_LOAD  = 3'b010;
  localparam logic [2:0] OP_STORE = 3'b011;
  localparam logic [2:0] OP_BR    = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_ILL   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_NEXT,
    S_HALT,
    S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         opcode_q, opcode_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic               vec_q, vec_d;
  logic [LANE_W-1:0]  lane_q, lane_d;

  // The loop ends after the current lane for scalar ops or on the final lane.
  logic lastLane;
  assign lastLane = !vec_q || (lane_q == LAST_LANE);

  // State, latched instruction fields and lane counter; reset aborts at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
      vec_q    <= 1'b0;
      lane_q   <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      vec_q    <= vec_d;
      lane_q   <= lane_d;
    end
  end

  // Next-state sequencing; a stalled cycle leaves everything as it was.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    vec_d    = vec_q;
    lane_d   = lane_q;
    if (!stall) begin
      case (state_q)
        S_FETCH: begin
          if (instr_valid) begin
            opcode_d = Opcode;
            funct_d  = Funct;
            vec_d    = Vec;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode_q == OP_ILL) begin
            state_d = S_ERROR;
          end else if (opcode_q == OP_HALT) begin
            state_d = S_HALT;
          end else begin
            lane_d  = '0;
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          case (opcode_q)
            OP_ALU, OP_ALUI:  state_d = S_WB;
            OP_LOAD, OP_STORE: state_d = S_MEM;
            default:          state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ack) begin
            state_d = (opcode_q == OP_LOAD) ? S_WB : S_NEXT;
          end
        end
        S_WB: begin
          state_d = S_NEXT;
        end
        S_NEXT: begin
          if (lastLane) begin
            lane_d  = '0;
            state_d = S_FETCH;
          end else begin
            lane_d  = lane_q + LANE_W'(1);
            state_d = S_EXEC;
          end
        end
        S_HALT:  state_d = S_HALT;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Moore output decode; strobes are masked while stalled.
  always_comb begin
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    pc_write    = 1'b0;
    RegWrite    = 1'b0;
    ImmSrc      = 1'b0;
    ALUSrc      = 1'b0;
    MemWrite    = 1'b0;
    MemRead     = 1'b0;
    MemtoReg    = 1'b0;
    AluOp       = '0;
    busy        = 1'b0;
    halted      = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        instr_ready = !stall;
      end
      S_DECODE: begin
        busy = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        case (opcode_q)
          OP_ALU: begin
            AluOp = funct_q;
          end
          OP_ALUI: begin
            AluOp  = funct_q;
            ALUSrc = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            ALUSrc = 1'b1;
          end
          OP_BR: begin
            AluOp    = FUNCT_W'(1);
            ImmSrc   = 1'b1;
            pc_write = !stall;
            PCSrc    = branch_taken;
          end
          OP_JMP: begin
            pc_write = !stall;
            PCSrc    = 1'b1;
          end
          default: begin
            AluOp = '0;
          end
        endcase
      end
      S_MEM: begin
        busy     = 1'b1;
        MemRead  = (opcode_q == OP_LOAD) && !stall;
        MemWrite = (opcode_q == OP_STORE) && !stall;
      end
      S_WB: begin
        busy     = 1'b1;
        RegWrite = !stall;
        MemtoReg = (opcode_q == OP_LOAD);
      end
      S_NEXT: begin
        busy     = 1'b1;
        pc_write = lastLane && !stall;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_ERROR: begin
        illegal = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign lane_idx = lane_q;

endmodule

// File: tb/tb_vector_control_fsm.sv
// tb_vector_control_fsm
// Random and directed instructions are expanded by a transaction-level model
// into a list of expected cycles (one entry per unstalled cycle, with the
// inputs to drive), then replayed against the DUT cycle by cycle.
module tb_vector_control_fsm;

  localparam int LANES   = 4;
  localparam int FUNCT_W = 3;
  localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;

  logic               clk;
  logic               rst;
  logic [2:0]         Opcode;
  logic [FUNCT_W-1:0] Funct;
  logic               Vec;
  logic               instr_valid;
  logic               instr_ready;
  logic               mem_ack;
  logic               branch_taken;
  logic               stall;
  logic               PCSrc;
  logic               pc_write;
  logic               RegWrite;
  logic               ImmSrc;
  logic               ALUSrc;
  logic               MemWrite;
  logic               MemRead;
  logic               MemtoReg;
  logic [FUNCT_W-1:0] AluOp;
  logic [LANE_W-1:0]  lane_idx;
  logic               busy;
  logic               halted;
  logic               illegal;

  typedef enum int {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_NEXT, P_STOP} phase_t;

  typedef struct {
    phase_t             ph;
    logic               vin;
    logic [2:0]         op;
    logic [FUNCT_W-1:0] fn;
    logic               vec;
    logic               ack;
    logic               bt;
    int                 stalls;
    logic               ir;
    logic               bsy;
    logic               pcw;
    logic               pcs;
    logic               rw;
    logic               mw;
    logic               mr;
    logic               m2r;
    logic               asrc;
    logic               imm;
    logic               hlt;
    logic               ill;
    logic [FUNCT_W-1:0] aop;
    int                 lane;
  } cyc_t;

  cyc_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   stallPct    = 0;

  vector_control_fsm #(.LANES(LANES), .FUNCT_W(FUNCT_W)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Vec(Vec),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .mem_ack(mem_ack),
    .branch_taken(branch_taken), .stall(stall), .PCSrc(PCSrc), .pc_write(pc_write),
    .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .AluOp(AluOp), .lane_idx(lane_idx),
    .busy(busy), .halted(halted), .illegal(illegal)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the replay ever loses track of time.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // An expected cycle with nothing asserted and random don't-care inputs.
  function automatic cyc_t blank(phase_t ph, int lane);
    cyc_t c;
    c.ph = ph; c.vin = 1'($urandom); c.op = 3'($urandom); c.fn = FUNCT_W'($urandom);
    c.vec = 1'($urandom); c.ack = 1'($urandom); c.bt = 1'($urandom);
    c.stalls = ($urandom_range(0, 99) < stallPct) ? int'($urandom_range(1, 2)) : 0;
    c.ir = 0; c.bsy = 0; c.pcw = 0; c.pcs = 0; c.rw = 0; c.mw = 0; c.mr = 0; c.m2r = 0;
    c.asrc = 0; c.imm = 0; c.hlt = 0; c.ill = 0; c.aop = '0; c.lane = lane;
    return c;
  endfunction

  // Expand one instruction into its expected cycles from the opcode rules.
  task automatic modelInstr(input logic [2:0] op, input logic [FUNCT_W-1:0] fn, input logic vec,
                            input logic bt, input int wbStall, input int memDelay);
    cyc_t c;
    int   idle;
    int   n;
    int   d;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      c = blank(P_IDLE, 0); c.vin = 0; c.ir = 1; expQ.push_back(c);
    end
    c = blank(P_FETCH, 0); c.vin = 1; c.op = op; c.fn = fn; c.vec = vec; c.ir = 1; expQ.push_back(c);
    c = blank(P_DECODE, 0); c.bsy = 1; expQ.push_back(c);
    if (op == 3'd6 || op == 3'd7) begin
      for (int i = 0; i < 4; i++) begin
        c = blank(P_STOP, 0); c.hlt = (op == 3'd7); c.ill = (op == 3'd6); expQ.push_back(c);
      end
      return;
    end
    n = (vec && op <= 3'd3) ? LANES : 1;
    for (int l = 0; l < n; l++) begin
      c = blank(P_EXEC, l); c.bsy = 1; c.bt = bt;
      c.aop  = (op <= 3'd1) ? fn : (op == 3'd4) ? FUNCT_W'(1) : '0;
      c.asrc = (op == 3'd1 || op == 3'd2 || op == 3'd3);
      c.imm  = (op == 3'd4);
      if (op == 3'd4) begin c.pcw = 1; c.pcs = bt; end
      if (op == 3'd5) begin c.pcw = 1; c.pcs = 1; end
      expQ.push_back(c);
      if (op >= 3'd4) return;
      if (op == 3'd2 || op == 3'd3) begin
        d = (memDelay < 0) ? int'($urandom_range(0, 3)) : memDelay;
        for (int k = 0; k <= d; k++) begin
          c = blank(P_MEM, l); c.bsy = 1; c.ack = (k == d);
          c.mr = (op == 3'd2); c.mw = (op == 3'd3); expQ.push_back(c);
        end
      end
      if (op != 3'd3) begin
        c = blank(P_WB, l); c.bsy = 1; c.rw = 1; c.m2r = (op == 3'd2);
        if (wbStall != 0) c.stalls = 3;
        expQ.push_back(c);
      end
      c = blank(P_NEXT, l); c.bsy = 1;
      if (l == n - 1) begin c.pcw = 1; c.pcs = 0; end
      expQ.push_back(c);
    end
  endtask

  task automatic compareCycle(input cyc_t c, input logic st);
    string p;
    int    strobes;
    p = c.ph.name();
    checkOutput({p, ".instr_ready"}, 32'(instr_ready), 32'(c.ir & ~st));
    checkOutput({p, ".busy"},        32'(busy),        32'(c.bsy));
    checkOutput({p, ".pc_write"},    32'(pc_write),    32'(c.pcw & ~st));
    checkOutput({p, ".RegWrite"},    32'(RegWrite),    32'(c.rw & ~st));
    checkOutput({p, ".MemWrite"},    32'(MemWrite),    32'(c.mw & ~st));
    checkOutput({p, ".MemRead"},     32'(MemRead),     32'(c.mr & ~st));
    checkOutput({p, ".halted"},      32'(halted),      32'(c.hlt));
    checkOutput({p, ".illegal"},     32'(illegal),     32'(c.ill));
    checkOutput({p, ".lane_idx"},    32'(lane_idx),    32'(c.lane));
    if (c.pcw && !st) checkOutput({p, ".PCSrc"}, 32'(PCSrc), 32'(c.pcs));
    if (c.ph == P_EXEC) begin
      checkOutput({p, ".AluOp"},  32'(AluOp),  32'(c.aop));
      checkOutput({p, ".ALUSrc"}, 32'(ALUSrc), 32'(c.asrc));
      checkOutput({p, ".ImmSrc"}, 32'(ImmSrc), 32'(c.imm));
    end
    if (c.ph == P_WB) checkOutput({p, ".MemtoReg"}, 32'(MemtoReg), 32'(c.m2r));
    strobes = int'(pc_write) + int'(RegWrite) + int'(MemWrite) + int'(MemRead);
    checkOutput({p, ".strobe_excl"}, 32'(strobes > 1), 32'd0);
  endtask

  // Replay one expected cycle, preceded by its stalled repeats.
  task automatic applyStimulus(input cyc_t c);
    for (int s = 0; s <= c.stalls; s++) begin
      logic st;
      st           = (s < c.stalls);
      stall        = st;
      instr_valid  = c.vin;
      Opcode       = c.op;
      Funct        = c.fn;
      Vec          = c.vec;
      mem_ack      = st ? 1'($urandom) : c.ack;
      branch_taken = c.bt;
      @(negedge clk);
      compareCycle(c, st);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runQueue();
    while (expQ.size() > 0) applyStimulus(expQ.pop_front());
  endtask

  // Assert reset wherever we are, check the reset outputs, release on negedge.
  task automatic doReset();
    stall = 0; instr_valid = 0; mem_ack = 0;
    rst = 0;
    #1;
    checkOutput("rst.instr_ready", 32'(instr_ready), 32'd1);
    checkOutput("rst.busy",        32'(busy),        32'd0);
    checkOutput("rst.pc_write",    32'(pc_write),    32'd0);
    checkOutput("rst.RegWrite",    32'(RegWrite),    32'd0);
    checkOutput("rst.MemWrite",    32'(MemWrite),    32'd0);
    checkOutput("rst.MemRead",     32'(MemRead),     32'd0);
    checkOutput("rst.halted",      32'(halted),      32'd0);
    checkOutput("rst.illegal",     32'(illegal),     32'd0);
    checkOutput("rst.lane_idx",    32'(lane_idx),    32'd0);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  // Directed scenarios first, then a randomized instruction stream with stalls.
  initial begin
    cyc_t cur;
    logic [2:0] op;
    int r;
    rst = 1; stall = 0; instr_valid = 0; mem_ack = 0; branch_taken = 0;
    Opcode = '0; Funct = '0; Vec = 0;
    #1;
    doReset();

    stallPct = 0;
    modelInstr(3'd0, 3'b010, 1'b0, 1'b0, 0, -1); runQueue();   // scalar add
    modelInstr(3'd2, 3'b101, 1'b1, 1'b0, 0, 2);  runQueue();   // vector load
    modelInstr(3'd4, 3'b000, 1'b0, 1'b1, 0, -1); runQueue();   // branch taken
    modelInstr(3'd4, 3'b111, 1'b1, 1'b0, 0, -1); runQueue();   // branch not taken, Vec ignored
    modelInstr(3'd5, 3'b011, 1'b1, 1'b0, 0, -1); runQueue();   // jump
    modelInstr(3'd1, 3'b110, 1'b0, 1'b0, 1, -1); runQueue();   // stall in WB
    modelInstr(3'd0, 3'b001, 1'b1, 1'b0, 1, -1); runQueue();   // vector stalls in WB
    modelInstr(3'd3, 3'b100, 1'b1, 1'b0, 0, 1);  runQueue();   // vector store

    // Reset while a store waits in MEM for its acknowledge.
    modelInstr(3'd3, 3'b000, 1'b0, 1'b0, 0, 3);
    while (expQ.size() > 1 && expQ[0].ph != P_MEM) applyStimulus(expQ.pop_front());
    cur = expQ.pop_front();
    stall = 0; instr_valid = cur.vin; Opcode = cur.op; Funct = cur.fn; Vec = cur.vec;
    mem_ack = 0; branch_taken = cur.bt;
    #2;
    checkOutput("abort.MemWrite_before", 32'(MemWrite), 32'd1);
    expQ.delete();
    doReset();
    modelInstr(3'd0, 3'b011, 1'b0, 1'b0, 0, -1); runQueue();

    modelInstr(3'd6, 3'b000, 1'b0, 1'b0, 0, -1); runQueue(); doReset();
    modelInstr(3'd7, 3'b000, 1'b0, 1'b0, 0, -1); runQueue(); doReset();

    stallPct = 15;
    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 19);
      op = (r == 0) ? 3'd6 : (r == 1) ? 3'd7 : 3'($urandom_range(0, 5));
      modelInstr(op, FUNCT_W'($urandom), 1'($urandom), 1'($urandom), 0, -1);
      runQueue();
      if (op >= 3'd6) doReset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/vector_control_fsm.md
VECTOR_CONTROL_FSM -- requirements
Module: vector_control_fsm

Interface
REQ-001 SHALL have parameter LANES, default 4, number of lanes a vector instruction iterates (>=1).
REQ-002 SHALL have parameter FUNCT_W, default 3, width of Funct and AluOp.
REQ-003 SHALL have localparam LANE_W = max(1, clog2(LANES)).
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports Opcode in 3, Funct in FUNCT_W, Vec in 1: instruction fields, sampled only on fetch handshake.
REQ-007 SHALL have ports instr_valid in 1 and instr_ready out 1: fetch handshake.
REQ-008 SHALL have ports mem_ack in 1 (data memory done), branch_taken in 1 (ALU zero/compare), stall in 1 (hazard hold).
REQ-009 SHALL have outputs PCSrc, pc_write, RegWrite, ImmSrc, ALUSrc, MemWrite, MemRead, MemtoReg (1 each) and AluOp (FUNCT_W).
REQ-010 SHALL have outputs lane_idx (LANE_W), busy (1), halted (1), illegal (1).

Function
REQ-011 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, NEXT, HALT, ERROR; all outputs Moore, decoded from state plus latched fields.
REQ-012 FETCH: instr_ready=1; on instr_valid=1 latch Opcode/Funct/Vec, go DECODE; else stay.
REQ-013 DECODE: one cycle; opcode 110 -> ERROR; 111 -> HALT; else lane_idx<=0, go EXEC.
REQ-014 Opcode map: 000 ALU-reg, 001 ALU-imm, 010 load, 011 store, 100 branch, 101 jump.
REQ-015 EXEC: AluOp=Funct for 000/001, all-zeros (add) for 010/011, 1 (sub) for 100; ALUSrc=1 for 001/010/011; ImmSrc=1 only for 100.
REQ-016 EXEC exits: 000/001 -> WB; 010/011 -> MEM; 100 -> pc_write=1, PCSrc=branch_taken, FETCH; 101 -> pc_write=1, PCSrc=1, FETCH.
REQ-017 MEM: MemRead=1 (load) or MemWrite=1 (store), held until mem_ack=1; then load -> WB, store -> NEXT.
REQ-018 WB: RegWrite=1 for exactly one cycle; MemtoReg=1 for load, 0 otherwise; go NEXT.
REQ-019 NEXT: if Vec=1 and lane_idx<LANES-1, lane_idx increments, go EXEC; else pc_write=1, PCSrc=0, lane_idx<=0, go FETCH.
REQ-020 Vec SHALL be ignored for 100/101 (scalar only); with LANES=1 vector behaves as scalar.
REQ-021 Scalar ALU instruction with instr_valid already high SHALL take 5 cycles FETCH->FETCH; vector adds 3 per extra lane (EXEC, WB, NEXT).
REQ-022 stall=1 SHALL freeze state and lane_idx and force RegWrite, MemWrite, MemRead, pc_write, instr_ready to 0; stall overrides mem_ack and instr_valid that cycle.
REQ-023 HALT: halted=1, busy=0; ERROR: illegal=1, busy=0; both terminal until reset; strobes 0.
REQ-024 busy SHALL be 1 in every state except FETCH, HALT, ERROR.
REQ-025 At most one of pc_write, RegWrite, MemWrite, MemRead SHALL be 1 in any cycle.

Reset
REQ-026 rst=0 SHALL immediately force state FETCH, lane_idx=0, latched fields 0, all outputs 0 except instr_ready=1.
REQ-027 Reset mid-operation (e.g. in MEM awaiting mem_ack) SHALL abort with no further strobes; after release, first action is a fresh fetch.

Verification
REQ-028 Scalar add: Opcode=000, Funct=010, Vec=0 -> DECODE, EXEC AluOp=010 ALUSrc=0, WB RegWrite=1 MemtoReg=0, NEXT pc_write=1 PCSrc=0; 5 cycles.
REQ-029 Vector load, LANES=4: Opcode=010, Vec=1, mem_ack after 2 cycles each lane -> 4 MemRead bursts, 4 RegWrite pulses MemtoReg=1, lane_idx 0..3, single pc_write.
REQ-030 Branch: Opcode=100, branch_taken=1 -> EXEC pc_write=1 PCSrc=1 ImmSrc=1 AluOp=001; branch_taken=0 -> PCSrc=0; no RegWrite.
REQ-031 Stall: stall=1 for 3 cycles in WB -> RegWrite 0 during stall, single RegWrite pulse after release, lane_idx unchanged.
REQ-032 Opcode=110 -> illegal=1 from cycle after DECODE, instr_ready=0 forever; Opcode=111 -> halted=1; both clear only on rst=0.
REQ-033 rst=0 asserted in MEM with MemWrite=1 -> MemWrite drops asynchronously, state FETCH, instr_ready=1 on release.
